// File: rtl/musb_add_arbiter.sv
// Three-requester arbiter in front of one shared combinational 32-bit adder.
// Round-robin or fixed-priority grant; one operation in flight, IDLE -> EXEC -> RESP.
module musb_add_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req_valid,
    input  logic [95:0] req_a,
    input  logic [95:0] req_b,
    output logic [2:0]  req_ready,
    output logic [2:0]  resp_valid,
    output logic [31:0] resp_result,
    input  logic [2:0]  resp_ready,
    output logic [31:0] add_port_a,
    output logic [31:0] add_port_b,
    input  logic [31:0] add_result,
    output logic        busy
);

    // Handshake: a request transfers on a rising edge where req_valid[i] && req_ready[i];
    // a response transfers on a rising edge where resp_valid[w] && resp_ready[w].
    // req_ready is a combinational one-hot grant offered only in IDLE; resp_valid holds until taken.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  last_grant;
    logic [1:0]  grant_q;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result_q;

    logic [1:0]  start;
    logic [2:0]  rot;
    logic [1:0]  offset;
    logic [2:0]  wsum;
    logic [2:0]  wwrap;
    logic [1:0]  winner;
    logic [31:0] sel_a;
    logic [31:0] sel_b;

    // rot[k] is the valid bit of requester (start+k) mod 3, so the first set bit is the winner.
    always_comb begin
        start = ((FIXED_PRIO != 0) || (last_grant == 2'd2)) ? 2'd0 : last_grant + 2'd1;
        case (start)
            2'd1:    rot = {req_valid[0], req_valid[2], req_valid[1]};
            2'd2:    rot = {req_valid[1], req_valid[0], req_valid[2]};
            default: rot = req_valid;
        endcase
        if (rot[0])
            offset = 2'd0;
        else if (rot[1])
            offset = 2'd1;
        else
            offset = 2'd2;
        wsum   = {1'b0, start} + {1'b0, offset};
        wwrap  = wsum - 3'd3;
        winner = (wsum >= 3'd3) ? wwrap[1:0] : wsum[1:0];
    end

    always_comb begin
        sel_a = req_a[31:0];
        sel_b = req_b[31:0];
        case (winner)
            2'd1: begin
                sel_a = req_a[63:32];
                sel_b = req_b[63:32];
            end
            2'd2: begin
                sel_a = req_a[95:64];
                sel_b = req_b[95:64];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 2'd2;
            grant_q    <= 2'd0;
            op_a       <= 32'h0;
            op_b       <= 32'h0;
            result_q   <= 32'h0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant_q <= winner;
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                    end
                end
                ST_EXEC: result_q <= add_result;
                ST_RESP: begin
                    if (resp_ready[grant_q])
                        last_grant <= grant_q;
                end
                default: ;
            endcase
        end
    end

    // The rst_n term keeps req_ready low while reset is held with requests pending.
    always_comb begin
        state_nxt   = state;
        req_ready   = 3'b000;
        resp_valid  = 3'b000;
        resp_result = 32'h0;
        add_port_a  = 32'h0;
        add_port_b  = 32'h0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (rst_n && (|req_valid)) begin
                    req_ready = 3'b001 << winner;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                add_port_a = op_a;
                add_port_b = op_b;
                state_nxt  = ST_RESP;
            end
            ST_RESP: begin
                resp_valid  = 3'b001 << grant_q;
                resp_result = result_q;
                if (resp_ready[grant_q])
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_musb_add_arbiter.sv
// Bench for musb_add_arbiter: a round-robin and a fixed-priority instance side by side,
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_musb_add_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  req_valid   [2];
    logic [95:0] req_a       [2];
    logic [95:0] req_b       [2];
    logic [2:0]  resp_ready  [2];
    logic [2:0]  req_ready   [2];
    logic [2:0]  resp_valid  [2];
    logic [31:0] resp_result [2];
    logic [31:0] add_port_a  [2];
    logic [31:0] add_port_b  [2];
    logic [31:0] add_result  [2];
    logic        busy        [2];

    // External shared adder, one per instance.
    assign add_result[0] = add_port_a[0] + add_port_b[0];
    assign add_result[1] = add_port_a[1] + add_port_b[1];

    musb_add_arbiter #(.FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_a(req_a[0]), .req_b(req_b[0]),
        .req_ready(req_ready[0]), .resp_valid(resp_valid[0]), .resp_result(resp_result[0]),
        .resp_ready(resp_ready[0]), .add_port_a(add_port_a[0]), .add_port_b(add_port_b[0]),
        .add_result(add_result[0]), .busy(busy[0])
    );

    musb_add_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_a(req_a[1]), .req_b(req_b[1]),
        .req_ready(req_ready[1]), .resp_valid(resp_valid[1]), .resp_result(resp_result[1]),
        .resp_ready(resp_ready[1]), .add_port_a(add_port_a[1]), .add_port_b(add_port_b[1]),
        .add_result(add_result[1]), .busy(busy[1])
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Model: one operation in flight, described by its age in cycles since acceptance.
    bit          m_active [2];
    int          m_age    [2];
    int          m_w      [2];
    int          m_last   [2];
    logic [31:0] m_a      [2];
    logic [31:0] m_b      [2];
    logic [31:0] m_sum    [2];
    int          gq0[$];
    int          gq1[$];

    function automatic int pick(input int inst, input logic [2:0] v);
        int idx;
        for (int k = 0; k < 3; k++) begin
            idx = (inst == 1) ? k : (m_last[inst] + 1 + k) % 3;
            if (v[idx])
                return idx;
        end
        return -1;
    endfunction

    logic [2:0]  e_ready;
    logic [2:0]  e_resp;
    logic [31:0] e_pa;
    logic [31:0] e_pb;
    logic        e_busy;
    int          p;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_active[i] = 1'b0;
                m_age[i]    = 0;
                m_last[i]   = 2;
                chk("rst_req_ready", i, 32'(req_ready[i]), 32'h0);
                chk("rst_resp_valid", i, 32'(resp_valid[i]), 32'h0);
                chk("rst_resp_result", i, resp_result[i], 32'h0);
                chk("rst_add_port_a", i, add_port_a[i], 32'h0);
                chk("rst_add_port_b", i, add_port_b[i], 32'h0);
                chk("rst_busy", i, 32'(busy[i]), 32'h0);
            end else begin
                p       = pick(i, req_valid[i]);
                e_ready = 3'b000;
                e_resp  = 3'b000;
                e_pa    = 32'h0;
                e_pb    = 32'h0;
                e_busy  = 1'b0;
                if (!m_active[i]) begin
                    if (p >= 0)
                        e_ready = 3'b001 << p;
                end else if (m_age[i] == 1) begin
                    e_pa   = m_a[i];
                    e_pb   = m_b[i];
                    e_busy = 1'b1;
                end else begin
                    e_resp = 3'b001 << m_w[i];
                    e_busy = 1'b1;
                end
                chk("req_ready", i, 32'(req_ready[i]), 32'(e_ready));
                chk("resp_valid", i, 32'(resp_valid[i]), 32'(e_resp));
                chk("add_port_a", i, add_port_a[i], e_pa);
                chk("add_port_b", i, add_port_b[i], e_pb);
                chk("busy", i, 32'(busy[i]), 32'(e_busy));
                if (e_resp != 3'b000)
                    chk("resp_result", i, resp_result[i], m_sum[i]);
                for (int k = 0; k < 3; k++) begin
                    if (req_ready[i][k]) begin
                        if (i == 0) gq0.push_back(k);
                        else        gq1.push_back(k);
                    end
                end
                if (!m_active[i]) begin
                    if (p >= 0) begin
                        m_active[i] = 1'b1;
                        m_age[i]    = 1;
                        m_w[i]      = p;
                        m_a[i]      = req_a[i][p*32 +: 32];
                        m_b[i]      = req_b[i][p*32 +: 32];
                        m_sum[i]    = m_a[i] + m_b[i];
                    end
                end else if (m_age[i] == 1) begin
                    m_age[i] = 2;
                end else if (resp_ready[i][m_w[i]]) begin
                    m_active[i] = 1'b0;
                    m_last[i]   = m_w[i];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 2; i++) begin
            req_a[i][r*32 +: 32] = a;
            req_b[i][r*32 +: 32] = b;
        end
    endtask

    task automatic set_valid(input logic [2:0] v);
        req_valid[0] = v;
        req_valid[1] = v;
    endtask

    task automatic set_rready(input logic [2:0] v);
        resp_ready[0] = v;
        resp_ready[1] = v;
    endtask

    task automatic wait_idle();
        int n;
        set_valid(3'b000);
        set_rready(3'b111);
        n = 0;
        while ((busy[0] || busy[1]) && n < 60) begin
            step();
            n++;
        end
        chk("idle_timeout", 0, 32'(busy[0]), 32'h0);
        chk("idle_timeout", 1, 32'(busy[1]), 32'h0);
    endtask

    task automatic chk_both(input string name, input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] exp);
        chk(name, 0, 32'(r0), 32'(exp));
        chk(name, 1, 32'(r1), 32'(exp));
    endtask

    logic [2:0]  snap [2];
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i]  = 3'b111;
            req_a[i]      = '0;
            req_b[i]      = '0;
            resp_ready[i] = 3'b000;
            m_last[i]     = 2;
        end
        // Reset held with requests pending: nothing may be granted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_both("rst_ready_gated", req_ready[0], req_ready[1], 3'b000);
        @(posedge clk);
        #1;
        set_valid(3'b000);
        rst_n = 1'b1;
        step();

        // Single op: 5 + 7 on requester 0.
        set_rready(3'b111);
        set_op(0, 32'h0000_0005, 32'h0000_0007);
        set_valid(3'b001);
        @(negedge clk);
        chk_both("single_grant", req_ready[0], req_ready[1], 3'b001);
        step();
        set_valid(3'b000);
        step();
        @(negedge clk);
        chk_both("single_resp_valid", resp_valid[0], resp_valid[1], 3'b001);
        chk("single_result", 0, resp_result[0], 32'h0000_000C);
        chk("single_result", 1, resp_result[1], 32'h0000_000C);
        step();
        chk("single_back_idle", 0, 32'(busy[0]), 32'h0);
        chk("single_back_idle", 1, 32'(busy[1]), 32'h0);

        // Wrap-around on requester 2.
        set_op(2, 32'hFFFF_FFFF, 32'h0000_0002);
        set_valid(3'b100);
        step();
        set_valid(3'b000);
        step();
        @(negedge clk);
        chk_both("wrap_resp_valid", resp_valid[0], resp_valid[1], 3'b100);
        chk("wrap_result", 0, resp_result[0], 32'h0000_0001);
        chk("wrap_result", 1, resp_result[1], 32'h0000_0001);
        wait_idle();

        // All three requesting continuously: grant order per policy.
        gq0.delete();
        gq1.delete();
        set_op(0, 32'h0000_0100, 32'h0000_0001);
        set_op(1, 32'h0000_0200, 32'h0000_0002);
        set_op(2, 32'h0000_0300, 32'h0000_0003);
        set_valid(3'b111);
        repeat (12) step();
        set_valid(3'b000);
        wait_idle();
        chk("rr_grant_count", 0, 32'(gq0.size() >= 4), 32'h1);
        chk("fp_grant_count", 1, 32'(gq1.size() >= 4), 32'h1);
        if (gq0.size() >= 4 && gq1.size() >= 4) begin
            chk("rr_order0", 0, 32'(gq0[0]), 32'd0);
            chk("rr_order1", 0, 32'(gq0[1]), 32'd1);
            chk("rr_order2", 0, 32'(gq0[2]), 32'd2);
            chk("rr_order3", 0, 32'(gq0[3]), 32'd0);
            for (int k = 0; k < 4; k++)
                chk("fp_order", 1, 32'(gq1[k]), 32'd0);
        end

        // Backpressure in RESP with requester 1 arriving meanwhile.
        set_rready(3'b000);
        set_op(0, 32'h1234_5678, 32'h1111_1111);
        set_valid(3'b001);
        step();
        set_valid(3'b010);
        step();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_both("bp_resp_valid", resp_valid[0], resp_valid[1], 3'b001);
            chk("bp_result", 0, resp_result[0], 32'h2345_6789);
            chk("bp_result", 1, resp_result[1], 32'h2345_6789);
            chk("bp_busy", 0, 32'(busy[0]), 32'h1);
            chk("bp_busy", 1, 32'(busy[1]), 32'h1);
            chk_both("bp_no_ready", req_ready[0], req_ready[1], 3'b000);
            step();
            if (k == 4)
                set_rready(3'b111);
        end
        chk("bp_idle", 0, 32'(busy[0]), 32'h0);
        chk("bp_idle", 1, 32'(busy[1]), 32'h0);
        @(negedge clk);
        chk_both("bp_pending_grant", req_ready[0], req_ready[1], 3'b010);
        step();
        wait_idle();

        // Asynchronous reset during EXEC.
        set_op(0, 32'h0000_0009, 32'h0000_0009);
        set_valid(3'b001);
        step();
        set_valid(3'b000);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_busy", i, 32'(busy[i]), 32'h0);
            chk("async_port_a", i, add_port_a[i], 32'h0);
            chk("async_port_b", i, add_port_b[i], 32'h0);
            chk("async_resp_valid", i, 32'(resp_valid[i]), 32'h0);
        end
        set_valid(3'b110);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_both("post_rst_grant", req_ready[0], req_ready[1], 3'b010);
        chk_both("post_rst_no_resp", resp_valid[0], resp_valid[1], 3'b000);
        step();
        wait_idle();

        // Randomized traffic, independent per instance.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            snap[0] = req_ready[0];
            snap[1] = req_ready[1];
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                for (int r = 0; r < 3; r++) begin
                    ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4)) : $urandom;
                    rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
                    if (snap[i][r]) begin
                        req_valid[i][r] = ($urandom_range(0, 1) == 1);
                        req_a[i][r*32 +: 32] = ra;
                        req_b[i][r*32 +: 32] = rb;
                    end else if (!req_valid[i][r]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            req_valid[i][r] = 1'b1;
                            req_a[i][r*32 +: 32] = ra;
                            req_b[i][r*32 +: 32] = rb;
                        end
                    end else if (busy[i] && $urandom_range(0, 3) == 0) begin
                        req_a[i][r*32 +: 32] = ra;
                        req_b[i][r*32 +: 32] = rb;
                    end
                end
                resp_ready[i] = 3'($urandom_range(0, 7));
            end
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
